mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 tb/tb_mult_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Start,
    input  logic [1:0]   Op,
    input  logic [N-1:0] OperandA,
    input  logic [N-1:0] OperandB,
    input  logic         HiWrite,
    input  logic         LoWrite,
    input  logic [N-1:0] WriteData,
    output logic         Busy,
    output logic         Done,
    output logic         DivByZero,
    output logic [N-1:0] HI,
    output logic [N-1:0] LO
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t         state, nextState;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   hiReg, loReg;
    logic [N:0]     rem;
    logic [N-1:0]   acc;
    logic [N-1:0]   divisor;
    logic           isDiv, negQ, negR, divZero;

    // Operand magnitudes and signs, only meaningful in the Start cycle
    logic           signedOp, signA, signB;
    logic [N-1:0]   magA, magB;

    // One radix-2 step of whichever operation is in flight
    logic [N:0]     mulSum, divShift, remStep;
    logic [N-1:0]   accStep;
    logic           divGe, lastStep;

    logic [2*N-1:0] prodMag, prodFix;
    logic [N-1:0]   quoFix, remFix, resHi, resLo;

    assign signedOp = ~Op[0];
    assign signA    = signedOp & OperandA[N-1];
    assign signB    = signedOp & OperandB[N-1];
    assign magA     = signA ? -OperandA : OperandA;
    assign magB     = signB ? -OperandB : OperandB;

    assign lastStep = (cnt == CW'(N - 1));

    always_comb begin
        mulSum   = rem + (acc[0] ? {1'b0, divisor} : {(N+1){1'b0}});
        divShift = {rem[N-1:0], acc[N-1]};
        divGe    = (divShift >= {1'b0, divisor});
        remStep  = rem;
        accStep  = acc;
        if (isDiv) begin
            remStep = divGe ? (divShift - {1'b0, divisor}) : divShift;
            accStep = {acc[N-2:0], divGe};
        end else begin
            remStep = {1'b0, mulSum[N:1]};
            accStep = {mulSum[0], acc[N-1:1]};
        end
    end

    // Sign correction is taken from the last step's outputs so HI/LO are
    // registered on the same edge that enters FINISH and are valid with Done.
    always_comb begin
        prodMag = {remStep[N-1:0], accStep};
        prodFix = negQ ? -prodMag : prodMag;
        quoFix  = negQ ? -accStep : accStep;
        remFix  = negR ? -remStep[N-1:0] : remStep[N-1:0];
        resHi   = prodFix[2*N-1:N];
        resLo   = prodFix[N-1:0];
        if (isDiv) begin
            resHi = remFix;
            resLo = divZero ? {N{1'b1}} : quoFix;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (Start) nextState = RUN;
            RUN:     if (lastStep) nextState = FINISH;
            FINISH:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            rem     <= '0;
            acc     <= '0;
            divisor <= '0;
            isDiv   <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (Start) begin
                        isDiv   <= Op[1];
                        negQ    <= signA ^ signB;
                        negR    <= signA;
                        divZero <= Op[1] && (OperandB == '0);
                        divisor <= magB;
                        acc     <= magA;
                        rem     <= '0;
                        cnt     <= '0;
                    end else begin
                        if (HiWrite) hiReg <= WriteData;
                        if (LoWrite) loReg <= WriteData;
                    end
                end
                RUN: begin
                    rem <= remStep;
                    acc <= accStep;
                    cnt <= cnt + CW'(1);
                    if (lastStep) begin
                        hiReg <= resHi;
                        loReg <= resLo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy      = (state == RUN);
    assign Done      = (state == FINISH);
    assign DivByZero = Done && divZero;
    assign HI        = hiReg;
    assign LO        = loReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          Start;
    logic [1:0]    Op;
    logic [N-1:0]  OperandA, OperandB, WriteData;
    logic          HiWrite, LoWrite;
    logic          Busy, Done, DivByZero;
    logic [N-1:0]  HI, LO;

    int            total = 0;
    int            bad = 0;
    logic [N-1:0]  expHi = '0;
    logic [N-1:0]  expLo = '0;

    mult_div_unit #(.N(N)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {DivByZero, HI, LO} from plain arithmetic
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = sa * sb; return {1'b0, p}; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
            2'd2: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit withWrite);
        logic [64:0] m;
        int          busyCnt, lat;
        bit          stable;
        m = model(op, a, b);
        @(negedge clk);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        if (withWrite) begin
            HiWrite = 1'b1; LoWrite = 1'b1; WriteData = $urandom;
        end
        @(negedge clk);
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        Op = 2'($urandom); OperandA = $urandom; OperandB = $urandom;
        busyCnt = 0; lat = 0; stable = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (Done) begin
                lat = i;
                break;
            end
            if (Busy) busyCnt++;
            if (HI !== expHi || LO !== expLo) stable = 1'b0;
            if (disturb && i == 5) begin
                HiWrite = 1'b1; LoWrite = 1'b1; WriteData = $urandom;
            end else if (disturb && i == 10) begin
                Start = 1'b1; Op = 2'($urandom);
            end else begin
                HiWrite = 1'b0; LoWrite = 1'b0; Start = 1'b0;
            end
            @(negedge clk);
        end
        HiWrite = 1'b0; LoWrite = 1'b0; Start = 1'b0;
        check("busy_cycles", 64'(busyCnt), 64'(N));
        check("done_latency", 64'(lat), 64'(N + 1));
        check("hilo_stable", 64'(stable), 64'd1);
        check("hi", 64'(HI), 64'(m[63:32]));
        check("lo", 64'(LO), 64'(m[31:0]));
        check("divbyzero", 64'(DivByZero), 64'(m[64]));
        expHi = m[63:32];
        expLo = m[31:0];
        @(negedge clk);
        check("done_pulse", 64'(Done), 64'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          doneSeen;

        reset = 1'b1; Start = 1'b0; Op = '0; OperandA = '0; OperandB = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);

        doOp(2'd0, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0);
        doOp(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        doOp(2'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
        doOp(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        doOp(2'd3, 32'h12345678, 32'h00000000, 1'b0, 1'b0);
        doOp(2'd2, 32'h87654321, 32'h00000000, 1'b0, 1'b0);
        doOp(2'd0, 32'h00001234, 32'h00005678, 1'b1, 1'b0);
        doOp(2'd3, 32'hDEADBEEF, 32'h00000013, 1'b0, 1'b1);

        // Register writes in IDLE land on the next edge
        @(negedge clk);
        HiWrite = 1'b1; WriteData = 32'hA5A5A5A5;
        @(negedge clk);
        HiWrite = 1'b0;
        check("mthi", 64'(HI), 64'hA5A5A5A5);
        expHi = 32'hA5A5A5A5;
        LoWrite = 1'b1; WriteData = 32'h5A5A0F0F;
        @(negedge clk);
        LoWrite = 1'b0;
        check("mtlo", 64'(LO), 64'h5A5A0F0F);
        check("mtlo_hi_kept", 64'(HI), 64'hA5A5A5A5);
        expLo = 32'h5A5A0F0F;

        // Reset in the middle of RUN aborts without a Done pulse
        @(negedge clk);
        Start = 1'b1; Op = 2'd1; OperandA = $urandom; OperandB = $urandom;
        @(negedge clk);
        Start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) doneSeen++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(doneSeen), 64'd0);
        expHi = '0;
        expLo = '0;
        doOp(2'd1, 32'd3, 32'd5, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = $urandom_range(1, 15);
                default: ;
            endcase
            doOp(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
